// File: rtl/code_entry_checker.sv
// ---------------------------------------------------------------------------
// code_entry_checker
//
// Collects one-cycle button-press pulses from the button monitor and checks
// the entered digit sequence against a stored passcode. Drives the lock
// open/closed state, pulses an error on a wrong entry and, optionally, locks
// the keypad out after repeated failures.
//
// Optional feature: define CODE_ENTRY_LOCKOUT_EN to compile in the failure
// counter and the LOCKOUT state. Without it, lockedOut is tied low and
// MAX_FAILS / LOCKOUT_CYCLES have no functional effect.
//
// Ports:
//   clock          in   system clock
//   reset          in   asynchronous, active-high reset
//   buttonPresses  in   [3:0] one-cycle press pulses, bit k = digit k
//   locked         out  high whenever the lock is not open
//   unlocked       out  high while open (always ~locked)
//   error          out  one-cycle pulse on a completed, mismatching entry
//   lockedOut      out  high during lockout
//   digitCount     out  [2:0] digits entered so far in this attempt
// ---------------------------------------------------------------------------
module code_entry_checker #(
  parameter int                      CODE_LEN       = 4,
  parameter logic [2*CODE_LEN-1:0]   DEFAULT_CODE   = 8'hE4,
  parameter int                      UNLOCK_CYCLES  = 50_000_000,
  parameter int                      ENTRY_TIMEOUT  = 250_000_000,
  parameter int                      MAX_FAILS      = 3,
  parameter int                      LOCKOUT_CYCLES = 500_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] buttonPresses,
  output logic       locked,
  output logic       unlocked,
  output logic       error,
  output logic       lockedOut,
  output logic [2:0] digitCount
);

  // Reject illegal parameterisations at elaboration time.
  if (CODE_LEN < 1 || CODE_LEN > 7) begin : g_bad_code_len
    $error("code_entry_checker: CODE_LEN must be in 1..7");
  end
  if (UNLOCK_CYCLES < 1 || ENTRY_TIMEOUT < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_cycles
    $error("code_entry_checker: cycle counts must be at least 1");
  end
  if (MAX_FAILS < 1 || MAX_FAILS > 3) begin : g_bad_max_fails
    $error("code_entry_checker: MAX_FAILS must be in 1..3");
  end

  // One shared timer serves the entry timeout, the open window and the
  // lockout window, since only one of them is ever running.
  localparam int max_ab      = (ENTRY_TIMEOUT > UNLOCK_CYCLES) ? ENTRY_TIMEOUT : UNLOCK_CYCLES;
  localparam int max_cycles  = (LOCKOUT_CYCLES > max_ab) ? LOCKOUT_CYCLES : max_ab;
  localparam int timer_width = ($clog2(max_cycles) < 1) ? 1 : $clog2(max_cycles);

  typedef logic [timer_width-1:0] timer_t;

  // The timer counts 0..N-1; reaching N-1 on an edge ends an N-cycle window.
  localparam timer_t entry_last  = timer_t'(ENTRY_TIMEOUT - 1);
  localparam timer_t unlock_last = timer_t'(UNLOCK_CYCLES - 1);
  localparam logic [2:0] code_last = 3'(CODE_LEN - 1);

`ifdef CODE_ENTRY_LOCKOUT_EN
  localparam timer_t     lockout_last = timer_t'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0] fail_limit   = 2'(MAX_FAILS);

  typedef enum logic [1:0] {IDLE, ENTRY, UNLOCKED, LOCKOUT} state_t;
`else
  typedef enum logic [1:0] {IDLE, ENTRY, UNLOCKED} state_t;
`endif

  state_t     state_reg, state_next;
  logic [2:0] count_reg, count_next;
  logic       mismatch_reg, mismatch_next;
  timer_t     timer_reg, timer_next;
  logic       error_next;
`ifdef CODE_ENTRY_LOCKOUT_EN
  logic [1:0] fail_reg, fail_next;
  logic [1:0] fail_inc;
`endif

  // Passcode split into per-digit slots; slots beyond CODE_LEN are never
  // addressed but keep the index width equal to digitCount's width.
  logic [1:0] code_digit [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_code_digit
    if (gi < CODE_LEN) begin : g_used
      assign code_digit[gi] = DEFAULT_CODE[2*gi +: 2];
    end else begin : g_unused
      assign code_digit[gi] = 2'b00;
    end
  end

  // Press decoding: one-hot is a real digit; several bits at once is still
  // one digit, but one that can never match.
  logic       press_any;
  logic       press_valid;
  logic [1:0] press_digit;
  logic       digit_bad;

  always_comb begin
    press_valid = 1'b1;
    press_digit = 2'd0;
    case (buttonPresses)
      4'b0001: press_digit = 2'd0;
      4'b0010: press_digit = 2'd1;
      4'b0100: press_digit = 2'd2;
      4'b1000: press_digit = 2'd3;
      default: press_valid = 1'b0;
    endcase
  end

  assign press_any = |buttonPresses;
  assign digit_bad = !press_valid || (press_digit != code_digit[count_reg]);

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    mismatch_next = mismatch_reg;
    timer_next    = (timer_reg != '1) ? timer_reg + timer_t'(1) : timer_reg;
    error_next    = 1'b0;
`ifdef CODE_ENTRY_LOCKOUT_EN
    fail_next     = fail_reg;
    fail_inc      = fail_reg + 2'd1;
`endif

    case (state_reg)
      IDLE, ENTRY: begin
        if (press_any) begin
          timer_next = '0;
          if (count_reg == code_last) begin
            // Final digit: evaluate the whole entry, including this digit.
            count_next    = 3'd0;
            mismatch_next = 1'b0;
            if (mismatch_reg || digit_bad) begin
              error_next = 1'b1;
              state_next = IDLE;
`ifdef CODE_ENTRY_LOCKOUT_EN
              fail_next = fail_inc;
              if (fail_inc >= fail_limit) begin
                state_next = LOCKOUT;
              end
`endif
            end else begin
              state_next = UNLOCKED;
`ifdef CODE_ENTRY_LOCKOUT_EN
              fail_next  = 2'd0;
`endif
            end
          end else begin
            count_next    = count_reg + 3'd1;
            mismatch_next = mismatch_reg | digit_bad;
            state_next    = ENTRY;
          end
        end else if (state_reg == ENTRY && timer_reg == entry_last) begin
          // Abandoned entry: silently discard, no error and no failure.
          state_next    = IDLE;
          count_next    = 3'd0;
          mismatch_next = 1'b0;
          timer_next    = '0;
        end else if (state_reg == IDLE) begin
          timer_next = '0;
        end
      end

      UNLOCKED: begin
        // Any press relocks; that press is swallowed, not taken as a digit.
        if (press_any || timer_reg == unlock_last) begin
          state_next = IDLE;
          timer_next = '0;
        end
      end

`ifdef CODE_ENTRY_LOCKOUT_EN
      LOCKOUT: begin
        // Presses are ignored here and do not restart the window.
        if (timer_reg == lockout_last) begin
          state_next = IDLE;
          fail_next  = 2'd0;
          timer_next = '0;
        end
      end
`endif

      default: begin
        state_next    = IDLE;
        count_next    = 3'd0;
        mismatch_next = 1'b0;
        timer_next    = '0;
      end
    endcase
  end

  // Outputs are registered from next-state values so that nothing reaches
  // the pins combinationally from buttonPresses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= 3'd0;
      mismatch_reg <= 1'b0;
      timer_reg    <= '0;
      locked       <= 1'b1;
      unlocked     <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      mismatch_reg <= mismatch_next;
      timer_reg    <= timer_next;
      locked       <= (state_next != UNLOCKED);
      unlocked     <= (state_next == UNLOCKED);
      error        <= error_next;
    end
  end

`ifdef CODE_ENTRY_LOCKOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fail_reg  <= 2'd0;
      lockedOut <= 1'b0;
    end else begin
      fail_reg  <= fail_next;
      lockedOut <= (state_next == LOCKOUT);
    end
  end
`else
  assign lockedOut = 1'b0;
`endif

  assign digitCount = count_reg;

endmodule

// File: tb/tb_code_entry_checker.sv
// ---------------------------------------------------------------------------
// tb_code_entry_checker
//
// Self-checking bench for code_entry_checker. A behavioural model keeps the
// entered digits in a queue and the open/lockout windows as countdowns, and
// predicts all outputs after every clock edge. Scenario tasks run directed
// sequences plus a randomized stretch, each comparing inline.
// Honours CODE_ENTRY_LOCKOUT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_code_entry_checker;

  localparam int         CODE_LEN       = 4;
  localparam logic [7:0] DEFAULT_CODE   = 8'hE4;
  localparam int         UNLOCK_CYCLES  = 16;
  localparam int         ENTRY_TIMEOUT  = 32;
  localparam int         MAX_FAILS      = 3;
  localparam int         LOCKOUT_CYCLES = 64;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] buttonPresses = 4'd0;
  logic       locked, unlocked, error, lockedOut;
  logic [2:0] digitCount;

  always #5 clock = ~clock;

  code_entry_checker #(
    .CODE_LEN      (CODE_LEN),
    .DEFAULT_CODE  (DEFAULT_CODE),
    .UNLOCK_CYCLES (UNLOCK_CYCLES),
    .ENTRY_TIMEOUT (ENTRY_TIMEOUT),
    .MAX_FAILS     (MAX_FAILS),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .buttonPresses(buttonPresses),
    .locked       (locked),
    .unlocked     (unlocked),
    .error        (error),
    .lockedOut    (lockedOut),
    .digitCount   (digitCount)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int entered[$];     // digits of the current attempt, -1 = multi-button
  int open_left;      // remaining open cycles
  int lock_left;      // remaining lockout cycles
  int idle_cnt;       // idle cycles since last press mid-entry
  bit err_m;
`ifdef CODE_ENTRY_LOCKOUT_EN
  int fails;
`endif

  localparam logic [6:0] RESET_VEC = 7'b1000000;

  function automatic int code_digit(input int i);
    logic [7:0] c;
    c = DEFAULT_CODE;
    return int'(c[2*i +: 2]);
  endfunction

  function automatic int decode(input logic [3:0] p);
    case (p)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    entered.delete();
    open_left = 0;
    lock_left = 0;
    idle_cnt  = 0;
    err_m     = 1'b0;
`ifdef CODE_ENTRY_LOCKOUT_EN
    fails     = 0;
`endif
  endtask

  task automatic model_step(input logic [3:0] p);
    bit ok;
    err_m = 1'b0;
    if (lock_left > 0) begin
      lock_left--;
`ifdef CODE_ENTRY_LOCKOUT_EN
      if (lock_left == 0) fails = 0;
`endif
    end else if (open_left > 0) begin
      if (p != 4'd0) open_left = 0;
      else open_left--;
    end else if (p != 4'd0) begin
      entered.push_back(decode(p));
      idle_cnt = 0;
      if (entered.size() == CODE_LEN) begin
        ok = 1'b1;
        for (int i = 0; i < CODE_LEN; i++)
          if (entered[i] != code_digit(i)) ok = 1'b0;
        entered.delete();
        if (ok) begin
          open_left = UNLOCK_CYCLES;
`ifdef CODE_ENTRY_LOCKOUT_EN
          fails = 0;
`endif
        end else begin
          err_m = 1'b1;
`ifdef CODE_ENTRY_LOCKOUT_EN
          fails++;
          if (fails >= MAX_FAILS) lock_left = LOCKOUT_CYCLES;
`endif
        end
      end
    end else if (entered.size() > 0) begin
      idle_cnt++;
      if (idle_cnt >= ENTRY_TIMEOUT) begin
        entered.delete();
        idle_cnt = 0;
      end
    end
  endtask

  function automatic logic [6:0] exp_vec();
    logic o;
    o = (open_left > 0);
    return {!o, o, err_m, (lock_left > 0), 3'(entered.size())};
  endfunction

  function automatic logic [6:0] obs_vec();
    return {locked, unlocked, error, lockedOut, digitCount};
  endfunction

  // Drive one cycle: input changes at negedge, DUT samples at posedge,
  // outputs are compared 1 time unit later.
  task automatic step(input logic [3:0] p);
    @(negedge clock);
    buttonPresses = p;
    @(posedge clock);
    model_step(p);
    #1;
    buttonPresses = 4'd0;
  endtask

  function automatic logic [3:0] digit_press(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return one << d;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (obs_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_held got=%b want=%b", obs_vec(), RESET_VEC);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(4'd0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_release cyc=%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_correct_code();
    int unl_cnt = 0;
    int err_cnt = 0;
    for (int d = 0; d < CODE_LEN; d++) begin
      for (int g = 0; g < 3; g++) begin
        step(4'd0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL correct_gap d=%0d got=%b want=%b", d, obs_vec(), exp_vec());
        end
      end
      step(digit_press(code_digit(d)));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL correct_press d=%0d got=%b want=%b", d, obs_vec(), exp_vec());
      end
    end
    if (unlocked) unl_cnt++;
    for (int i = 0; i < 22; i++) begin
      step(4'd0);
      if (unlocked) unl_cnt++;
      if (error) err_cnt++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL correct_open cyc=%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (unl_cnt !== UNLOCK_CYCLES || err_cnt !== 0) begin
      errors++;
      $display("FAIL correct_window open_cycles=%0d errors=%0d want %0d and 0",
               unl_cnt, err_cnt, UNLOCK_CYCLES);
    end
  endtask

  task automatic test_wrong_code();
    int seq[4] = '{0, 1, 2, 2};
    foreach (seq[i]) begin
      step(digit_press(seq[i]));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL wrong_press i=%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if ({error, locked, digitCount} !== {1'b1, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL wrong_eval err=%b locked=%b cnt=%0d want 1 1 0", error, locked, digitCount);
    end
    step(digit_press(0));   // arrives in the error cycle
    checks++;
    if ({error, digitCount} !== {1'b0, 3'd1}) begin
      errors++;
      $display("FAIL wrong_errcycle err=%b cnt=%0d want 0 1", error, digitCount);
    end
    for (int i = 0; i < ENTRY_TIMEOUT + 1; i++) begin
      step(4'd0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL wrong_drain cyc=%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_multi_button_relock();
    logic [3:0] seq[4] = '{4'b0001, 4'b0110, 4'b0100, 4'b1000};
    foreach (seq[i]) begin
      step(seq[i]);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL multi_press i=%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL multi_error err=%b want 1", error);
    end
    for (int d = 0; d < CODE_LEN; d++) step(digit_press(code_digit(d)));
    checks++;
    if (unlocked !== 1'b1) begin
      errors++;
      $display("FAIL relock_open unlocked=%b want 1", unlocked);
    end
    repeat (3) step(4'd0);
    step(4'b0010);
    checks++;
    if ({unlocked, locked, digitCount} !== {1'b0, 1'b1, 3'd0} || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL relock_press got=%b want=%b", obs_vec(), exp_vec());
    end
    repeat (3) step(4'd0);
  endtask

  task automatic test_timeout();
    step(digit_press(0));
    step(digit_press(1));
    for (int i = 0; i < ENTRY_TIMEOUT - 1; i++) begin
      step(4'd0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL timeout_wait cyc=%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (digitCount !== 3'd2) begin
      errors++;
      $display("FAIL timeout_early cnt=%0d want 2", digitCount);
    end
    step(4'd0);
    checks++;
    if ({digitCount, error} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_expire cnt=%0d err=%b want 0 0", digitCount, error);
    end
    for (int d = 0; d < CODE_LEN; d++) step(digit_press(code_digit(d)));
    checks++;
    if (unlocked !== 1'b1) begin
      errors++;
      $display("FAIL timeout_then_open unlocked=%b want 1", unlocked);
    end
    repeat (UNLOCK_CYCLES + 1) step(4'd0);
  endtask

  task automatic test_lockout();
    int err_cnt = 0;
    int lo_cnt  = 0;
    for (int a = 0; a < 3; a++) begin
      for (int d = 0; d < CODE_LEN; d++) begin
        step(digit_press(0));
        if (error) err_cnt++;
      end
    end
    checks++;
    if (err_cnt !== 3 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL lockout_errors count=%0d want 3, got=%b want=%b", err_cnt, obs_vec(), exp_vec());
    end
`ifdef CODE_ENTRY_LOCKOUT_EN
    if (lockedOut) lo_cnt++;
    for (int d = 0; d < CODE_LEN; d++) begin
      step(digit_press(code_digit(d)));
      if (lockedOut) lo_cnt++;
      checks++;
      if ({unlocked, digitCount, lockedOut} !== {1'b0, 3'd0, 1'b1}) begin
        errors++;
        $display("FAIL lockout_ignore d=%0d unl=%b cnt=%0d lo=%b want 0 0 1",
                 d, unlocked, digitCount, lockedOut);
      end
    end
    for (int i = 0; i < LOCKOUT_CYCLES + 4; i++) begin
      step(4'd0);
      if (lockedOut) lo_cnt++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL lockout_window cyc=%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (lo_cnt !== LOCKOUT_CYCLES) begin
      errors++;
      $display("FAIL lockout_length cycles=%0d want %0d", lo_cnt, LOCKOUT_CYCLES);
    end
`else
    checks++;
    if (lockedOut !== 1'b0) begin
      errors++;
      $display("FAIL lockout_disabled lo=%b want 0", lockedOut);
    end
`endif
    for (int d = 0; d < CODE_LEN; d++) step(digit_press(code_digit(d)));
    checks++;
    if ({unlocked, lockedOut} !== {1'b1, 1'b0}) begin
      errors++;
      $display("FAIL lockout_after unl=%b lo=%b want 1 0", unlocked, lockedOut);
    end
    repeat (UNLOCK_CYCLES + 1) step(4'd0);
  endtask

  task automatic test_async_reset();
    step(digit_press(0));
    step(digit_press(1));
    reset = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL async_mid_entry got=%b want=%b", obs_vec(), RESET_VEC);
    end
    model_reset();
    #1 reset = 1'b0;
    for (int d = 0; d < CODE_LEN; d++) step(digit_press(code_digit(d)));
    repeat (5) step(4'd0);
    checks++;
    if (unlocked !== 1'b1) begin
      errors++;
      $display("FAIL async_reopen unlocked=%b want 1", unlocked);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL async_mid_unlock got=%b want=%b", obs_vec(), RESET_VEC);
    end
    model_reset();
    #1 reset = 1'b0;
    for (int d = 0; d < CODE_LEN; d++) step(digit_press(code_digit(d)));
    checks++;
    if (obs_vec() !== exp_vec() || unlocked !== 1'b1) begin
      errors++;
      $display("FAIL async_after got=%b want=%b", obs_vec(), exp_vec());
    end
    repeat (UNLOCK_CYCLES + 1) step(4'd0);
  endtask

  task automatic test_random();
    int r;
    logic [3:0] p;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55) p = 4'd0;
      else if (r < 90) p = digit_press(code_digit(entered.size()));
      else p = 4'($urandom_range(1, 15));
      step(p);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d press=%b got=%b want=%b", i, p, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_correct_code();
    test_wrong_code();
    test_multi_button_relock();
    test_timeout();
    test_lockout();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
